// File: rtl/seg7_pkg.sv
// Shared seven-segment types and constants, used by the encoder stage and the scan driver.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package seg7_pkg;

    localparam int SEG_W = 7;

    // bit0 = segment a ... bit6 = segment g, 1 = lit
    typedef logic [SEG_W-1:0] seg_t;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ON
    } scan_state_t;

    localparam seg_t SEG_OFF = 7'b0;

    // Apply pad polarity to an active-high segment pattern
    function automatic seg_t seg_drive(input seg_t pat, input logic active_low);
        return active_low ? ~pat : pat;
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Slot timer for the scan driver: slot cycle counter, digit index and slot strobes.
// Latency: counters update on every edge; strobes decode the current count combinationally.
// Backpressure: none; counts free-running unless cleared.
module seg7_slot_timer #(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    output logic [$clog2(N_DIGITS)-1:0]    digit_idx,
    output logic [$clog2(N_DIGITS)-1:0]    digit_nxt,
    output logic [$clog2(REFRESH_DIV)-1:0] slot_nxt,
    output logic                           blank_end,
    output logic                           slot_end,
    output logic                           frame_end
);
    import seg7_pkg::*;

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int DW = $clog2(N_DIGITS);

    logic [CW-1:0] slot_cnt;

    assign blank_end = (slot_cnt == CW'(BLANK_CYCLES - 1));
    assign slot_end  = (slot_cnt == CW'(REFRESH_DIV - 1));
    assign frame_end = slot_end && (digit_idx == DW'(N_DIGITS - 1));

    // Next count values; exported so the driver can register outputs that match them
    always_comb begin
        slot_nxt  = slot_cnt;
        digit_nxt = digit_idx;
        if (clear) begin
            slot_nxt  = '0;
            digit_nxt = '0;
        end else if (slot_end) begin
            slot_nxt  = '0;
            digit_nxt = (digit_idx == DW'(N_DIGITS - 1)) ? '0 : digit_idx + DW'(1);
        end else begin
            slot_nxt  = slot_cnt + CW'(1);
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            slot_cnt  <= slot_nxt;
            digit_idx <= digit_nxt;
        end
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed 7-seg driver: double-buffered patterns, blanked digit slots, optional PWM brightness (SEG7_SCAN_BRIGHTNESS_EN).
// Latency: all outputs registered; outputs after an edge reflect the state entered on that edge. New patterns appear at the next frame.
// Backpressure: none; load is always accepted, and the last load before a frame boundary wins.
module seg7_scan_mux #(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        load,
    input  logic [7*N_DIGITS-1:0]       seg_in,
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    input  logic [2:0]                  brightness,
`endif
    output logic [6:0]                  seg_out,
    output logic [N_DIGITS-1:0]         an_out,
    output logic [$clog2(N_DIGITS)-1:0] digit_idx,
    output logic                        frame_done
);
    import seg7_pkg::*;

    localparam int CW     = $clog2(REFRESH_DIV);
    localparam int DW     = $clog2(N_DIGITS);
    localparam int ON_LEN = REFRESH_DIV - BLANK_CYCLES;

    localparam logic              SEG_LOW  = (SEG_ACTIVE_LOW != 0);
    localparam logic              AN_LOW   = (AN_ACTIVE_LOW != 0);
    localparam seg_t              SEG_IDLE = SEG_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [N_DIGITS-1:0] AN_OFF = AN_LOW ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
    localparam logic [N_DIGITS-1:0] AN_ONE = N_DIGITS'(1);

    scan_state_t           state;
    seg_t [N_DIGITS-1:0]   pending_q;
    seg_t [N_DIGITS-1:0]   active_q;
    seg_t [N_DIGITS-1:0]   pend_nxt;
    seg_t [N_DIGITS-1:0]   active_nxt;

    logic [DW-1:0]         digit_nxt;
    logic [CW-1:0]         slot_nxt;
    logic                  blank_end;
    logic                  slot_end;
    logic                  frame_end;
    logic                  tmr_clear;
    logic                  slot_start;
    logic                  frame_load;
    logic                  frame_last_nxt;
    logic                  bright_ok;
    logic [N_DIGITS-1:0]   an_sel;
    logic [N_DIGITS-1:0]   an_on;

    // Counters are held at zero whenever the scan is stopped
    assign tmr_clear = !en || (state == IDLE);

    seg7_slot_timer #(
        .N_DIGITS     (N_DIGITS),
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear),
        .digit_idx (digit_idx),
        .digit_nxt (digit_nxt),
        .slot_nxt  (slot_nxt),
        .blank_end (blank_end),
        .slot_end  (slot_end),
        .frame_end (frame_end)
    );

    // Buffer steering: a load coinciding with a frame start bypasses straight into active
    always_comb begin
        slot_start     = en && ((state == IDLE) || ((state == ON) && slot_end));
        frame_load     = en && ((state == IDLE) || ((state == ON) && frame_end));
        pend_nxt       = load ? seg_in : pending_q;
        active_nxt     = frame_load ? pend_nxt : active_q;
        frame_last_nxt = (digit_nxt == DW'(N_DIGITS - 1)) && (slot_nxt == CW'(REFRESH_DIV - 1));
    end

`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [2:0]  bright_q;
    logic [31:0] on_cnt;
    logic [31:0] on_lim;

    // Brightness is latched once per slot so the duty cycle never changes mid-digit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= '0;
        end else if (slot_start) begin
            bright_q <= brightness;
        end
    end

    // Anode stays lit only for the first (brightness+1)/8 of the on-time
    always_comb begin
        on_cnt    = 32'(slot_nxt) - 32'(BLANK_CYCLES);
        on_lim    = ((32'(bright_q) + 32'd1) * 32'(ON_LEN)) >> 3;
        bright_ok = (on_cnt < on_lim);
    end
`else
    assign bright_ok = 1'b1;
`endif

    // Anode pattern for the digit that will be current after this edge
    always_comb begin
        an_sel = bright_ok ? (AN_ONE << digit_nxt) : '0;
        an_on  = AN_LOW ? ~an_sel : an_sel;
    end

    // Scan FSM with buffers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pending_q  <= '0;
            active_q   <= '0;
            seg_out    <= SEG_IDLE;
            an_out     <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            pending_q  <= pend_nxt;
            active_q   <= active_nxt;
            frame_done <= 1'b0;
            seg_out    <= seg_drive(active_nxt[digit_nxt], SEG_LOW);
            if (!en) begin
                state   <= IDLE;
                an_out  <= AN_OFF;
                seg_out <= SEG_IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        state  <= BLANK;
                        an_out <= AN_OFF;
                    end
                    BLANK: begin
                        if (blank_end) begin
                            state      <= ON;
                            an_out     <= an_on;
                            frame_done <= frame_last_nxt;
                        end else begin
                            an_out <= AN_OFF;
                        end
                    end
                    ON: begin
                        if (slot_end) begin
                            state  <= BLANK;
                            an_out <= AN_OFF;
                        end else begin
                            an_out     <= an_on;
                            frame_done <= frame_last_nxt;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        an_out <= AN_OFF;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Directed bench for seg7_scan_mux with N_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, active-low pads.
// Latency: each frame is 32 cycles; outputs sampled 1 time unit after the rising edge.
// Backpressure: not applicable.
module tb_seg7_scan_mux;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load = 1'b0;
    logic [27:0] seg_in = '0;
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic [1:0]  digit_idx;
    logic        frame_done;
`ifdef SEG7_SCAN_BRIGHTNESS_EN
    logic [2:0]  brightness = 3'd7;
`endif

    int total = 0;
    int passed = 0;

    localparam logic [27:0] PAT_A = {7'h06, 7'h5B, 7'h4F, 7'h66};
    localparam logic [27:0] PAT_B = {7'h7F, 7'h07, 7'h7D, 7'h6D};
    localparam logic [27:0] PAT_C = {7'h77, 7'h7C, 7'h39, 7'h5E};
    localparam logic [27:0] PAT_D = {7'h79, 7'h71, 7'h3F, 7'h06};
    localparam logic [27:0] PAT_E = {7'h01, 7'h02, 7'h04, 7'h08};
    localparam logic [27:0] PAT_F = {7'h40, 7'h20, 7'h10, 7'h3F};

    always #5 clk = ~clk;

    seg7_scan_mux #(
        .N_DIGITS       (4),
        .REFRESH_DIV    (8),
        .BLANK_CYCLES   (2),
        .SEG_ACTIVE_LOW (1),
        .AN_ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seg_in     (seg_in),
`ifdef SEG7_SCAN_BRIGHTNESS_EN
        .brightness (brightness),
`endif
        .seg_out    (seg_out),
        .an_out     (an_out),
        .digit_idx  (digit_idx),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, " an"},    32'(an_out),     32'h0000_000F);
        chk({tag, " seg"},   32'(seg_out),    32'h0000_007F);
        chk({tag, " fd"},    32'(frame_done), 32'h0);
        chk({tag, " digit"}, 32'(digit_idx),  32'h0);
    endtask

    // Walk one frame from its first blank cycle (t=0), checking every output each cycle.
    // lit = anode on-cycles per slot; optional loads at l1_t/l2_t; en dropped before the edge after drop_t.
    task automatic run_frame(input logic [27:0] pats, input int lit, input int last_t, input int drop_t,
                             input int l1_t, input logic [27:0] l1_dat,
                             input int l2_t, input logic [27:0] l2_dat);
        for (int t = 0; t <= last_t; t++) begin
            int d;
            int s;
            logic [3:0] ea;
            logic [6:0] es;
            d  = t / 8;
            s  = t % 8;
            ea = (s >= 2 && (s - 2) < lit) ? ~(4'b0001 << d) : 4'b1111;
            es = ~pats[7*d +: 7];
            chk($sformatf("an t=%0d", t),    32'(an_out),     32'(ea));
            chk($sformatf("seg t=%0d", t),   32'(seg_out),    32'(es));
            chk($sformatf("digit t=%0d", t), 32'(digit_idx),  32'(d));
            chk($sformatf("fd t=%0d", t),    32'(frame_done), (t == 31) ? 32'h1 : 32'h0);
            if (t == l1_t) begin
                load   = 1'b1;
                seg_in = l1_dat;
            end
            if (t == l2_t) begin
                load   = 1'b1;
                seg_in = l2_dat;
            end
            if (t == drop_t) en = 1'b0;
            step();
            load = 1'b0;
        end
    endtask

    initial begin
        // Reset held with en high: everything dark
        rst_n = 1'b0;
        en    = 1'b1;
        step();
        step();
        chk_dark("reset");

        // Release, load first pattern set, then enable
        rst_n  = 1'b1;
        en     = 1'b0;
        load   = 1'b1;
        seg_in = PAT_A;
        step();
        load   = 1'b0;
        chk_dark("idle");
        en = 1'b1;
        step();

        // Basic scan frame
        run_frame(PAT_A, 6, 31, -1, -1, '0, -1, '0);
        // Load mid-frame: old patterns stay for the whole frame
        run_frame(PAT_A, 6, 31, -1, 10, PAT_B, -1, '0);
        // New data shown; two loads in this frame
        run_frame(PAT_B, 6, 31, -1, 5, PAT_C, 20, PAT_D);
        // Only the second load shows; load on the wrap edge
        run_frame(PAT_D, 6, 31, -1, 31, PAT_E, -1, '0);
        // Boundary load visible at once; drop en during digit 2 ON
        run_frame(PAT_E, 6, 19, 19, -1, '0, -1, '0);
        chk_dark("en drop");
        step();
        chk_dark("en low");

        // Re-enable restarts at digit 0 with the kept pending data
        en = 1'b1;
        step();
        run_frame(PAT_E, 6, 4, -1, -1, '0, -1, '0);
        chk("pre-reset an lit", 32'(an_out), 32'h0000_000E);

        // Asynchronous reset mid-ON, no clock edge needed
        rst_n = 1'b0;
        #1;
        chk_dark("async reset");
        #2;
        rst_n = 1'b1;
        step();
        // Buffers were cleared by reset, so every digit is blank
        run_frame(28'h0, 6, 31, -1, -1, '0, -1, '0);

`ifdef SEG7_SCAN_BRIGHTNESS_EN
        en     = 1'b0;
        load   = 1'b1;
        seg_in = PAT_F;
        brightness = 3'd3;
        step();
        load = 1'b0;
        en   = 1'b1;
        step();
        run_frame(PAT_F, 3, 31, -1, -1, '0, -1, '0);
        en = 1'b0;
        brightness = 3'd7;
        step();
        en = 1'b1;
        step();
        run_frame(PAT_F, 6, 31, -1, -1, '0, -1, '0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexed seven-segment display driver, directly downstream of the adder/7-seg encoder stage.
- Accepts N_DIGITS 7-bit segment patterns and drives one shared segment bus plus one anode-select line per digit.
- Double-buffered input prevents tearing; a blanking interval between digits prevents ghosting.

Parameters:
- N_DIGITS, 4, number of digits scanned (2..8).
- REFRESH_DIV, 50000, clock cycles per digit slot (blank + on).
- BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; legal range 1 ≤ BLANK_CYCLES < REFRESH_DIV.
- SEG_ACTIVE_LOW, 1, 1 = seg_out inverted (0 lights a segment).
- AN_ACTIVE_LOW, 1, 1 = an_out inverted (0 enables a digit).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; low = display dark.
- load  in  1  single-cycle strobe; captures seg_in into the pending buffer.
- seg_in  in  7*N_DIGITS  digit k at seg_in[7*k +: 7]; bit0 = seg a … bit6 = seg g; active-high (1 = lit).
- seg_out  out  7  shared segment bus, polarity per SEG_ACTIVE_LOW.
- an_out  out  N_DIGITS  one-hot digit enable, polarity per AN_ACTIVE_LOW.
- digit_idx  out  $clog2(N_DIGITS)  index of the current slot.
- frame_done  out  1  one-cycle pulse at the end of a full scan.

Behaviour:
- All outputs are registered. Clock is clk; reset is asynchronous, active-low, on rst_n.
- Reset, applied immediately:
  - state = IDLE; pending and active buffers = 0; slot_cnt = 0; digit_idx = 0; frame_done = 0.
  - an_out and seg_out are all-inactive, meaning all 1s when the corresponding *_ACTIVE_LOW = 1.
- FSM states: IDLE, BLANK, ON.
  - IDLE: outputs inactive. When en = 1, go to BLANK on the next edge with digit_idx = 0 and slot_cnt = 0; active ← pending.
  - BLANK: an_out inactive; seg_out = active pattern of digit_idx, pre-driven. slot_cnt increments. When slot_cnt = BLANK_CYCLES-1, go to ON.
  - ON: an_out has only bit digit_idx asserted; seg_out = active[digit_idx]. When slot_cnt = REFRESH_DIV-1:
    - slot_cnt ← 0; digit_idx ← (digit_idx+1) mod N_DIGITS; go to BLANK.
    - Wrap from N_DIGITS-1 to 0 is the frame boundary: active ← pending, and frame_done pulses on this last ON cycle of digit N_DIGITS-1.
- Each digit slot is exactly REFRESH_DIV cycles: BLANK_CYCLES blank followed by REFRESH_DIV-BLANK_CYCLES lit. A frame is N_DIGITS*REFRESH_DIV cycles.
- Load rules:
  - load: pending ← seg_in on the same edge; takes effect at the next frame boundary, never mid-frame.
  - Several loads within one frame: the last one wins.
  - load on the frame-boundary edge: the new seg_in goes straight to active and is displayed in the frame that starts.
- en deasserted in any state: IDLE on the next edge, outputs inactive, counters cleared, pending kept. Re-enable restarts at digit 0 BLANK.
- Never more than one anode asserted. Anodes are never asserted during BLANK or IDLE.
- rst_n asserted mid-scan: outputs go inactive asynchronously. After release, the block restarts from IDLE.

Optional Feature:
- Macro SEG7_SCAN_BRIGHTNESS_EN.
- Defined:
  - Adds port brightness, in, 3 bits, sampled at each slot start.
  - Let L = REFRESH_DIV-BLANK_CYCLES and on_cnt = slot_cnt-BLANK_CYCLES.
  - During ON, the anode is asserted only while on_cnt < ((brightness+1)*L)>>3. It is inactive for the rest of the slot, with seg_out unchanged.
  - brightness = 7 gives full on-time.
- Undefined: no brightness port; full on-time always.

Decomposition:
- Package seg7_pkg:
  - SEG_W = 7.
  - Typedef seg_t (logic [6:0]).
  - Typedef for the scan FSM state enum (IDLE, BLANK, ON).
  - Constant SEG_OFF = 7'b0.
  - This package is shared with the encoder stage upstream.
- One sub-module, seg7_slot_timer: holds slot_cnt and digit_idx, and emits the blank_end, slot_end and frame_end strobes. The FSM, buffers and output registers stay in seg7_scan_mux.

Test Plan:
All scenarios use N_DIGITS = 4, REFRESH_DIV = 8, BLANK_CYCLES = 2, both polarities = 1.
- Reset: hold rst_n = 0 with en = 1 → an_out = 4'b1111, seg_out = 7'b1111111, frame_done = 0. Asserting rst_n mid-ON returns the same values immediately, with no clock edge.
- Basic scan:
  - Stimulus: load seg_in = {7'h06, 7'h5B, 7'h4F, 7'h66}, then en = 1.
  - an_out sequence per slot: 2 cycles of 1111, then 6 cycles of 1110; then 1101, 1011, 0111 in turn.
  - seg_out = ~7'h66 while digit 0 is lit.
  - frame_done pulses once every 32 cycles.
- Double buffer: load new data in cycle 10 of a frame → the old patterns persist until cycle 32; the new patterns are shown from digit 0 of the next frame. Two loads in one frame → only the second appears.
- Boundary load: load asserted exactly on the frame-wrap edge → the new pattern is visible in digit 0 of the frame that starts.
- Enable drop: deassert en during digit 2 ON → next cycle an_out = 1111. Re-assert → 2 blank cycles, then digit 0 is lit.
- Brightness (macro defined): brightness = 3 → anode asserted for 3 of the 6 ON cycles per slot; brightness = 7 → 6 of 6.
